// File: rtl/mips_ctrl_if.sv
// Bundles the signals between the multicycle MIPS main control FSM and its datapath.
// master = control unit, slave = datapath.
`timescale 1ns/1ps
interface mips_ctrl_if;
   logic [5:0] opcode;
   logic       zero;
   logic       jr;
   logic       mem_ready;
   logic       pcwrite;
   logic       branch;
   logic       pc_en;
   logic [1:0] pcsrc;
   logic       iord;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic       imm_zext;
   logic       illegal_op;
   logic [3:0] state_o;

   modport master (
      input  opcode, zero, jr, mem_ready,
      output pcwrite, branch, pc_en, pcsrc, iord, irwrite, memwrite, regwrite,
             regdst, memtoreg, alusrca, alusrcb, aluop, imm_zext, illegal_op, state_o
   );

   modport slave (
      output opcode, zero, jr, mem_ready,
      input  pcwrite, branch, pc_en, pcsrc, iord, irwrite, memwrite, regwrite,
             regdst, memtoreg, alusrca, alusrcb, aluop, imm_zext, illegal_op, state_o
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, drives aluop into alu_control and stalls on mem_ready.
`timescale 1ns/1ps
module mips_multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   mips_ctrl_if.master ctrl
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_IMMWB   = 4'd10;
   localparam logic [3:0] S_ANDIEX  = 4'd11;
   localparam logic [3:0] S_JUMP    = 4'd12;

   logic [3:0] state, next_state;
   logic       pcwrite_c, branch_c, iord_c, irwrite_c, memwrite_c, regwrite_c;
   logic       regdst_c, memtoreg_c, alusrca_c, imm_zext_c, illegal_c;
   logic [1:0] pcsrc_c, alusrcb_c, aluop_c;
   logic       pcwrite_g;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= next_state;
   end

   always_comb begin
      // NOTE: every output gets a default up front; a path that forgets one would infer a latch.
      next_state = S_FETCH;
      pcwrite_c  = 1'b0;
      branch_c   = 1'b0;
      pcsrc_c    = 2'b00;
      iord_c     = 1'b0;
      irwrite_c  = 1'b0;
      memwrite_c = 1'b0;
      regwrite_c = 1'b0;
      regdst_c   = 1'b0;
      memtoreg_c = 1'b0;
      alusrca_c  = 1'b0;
      alusrcb_c  = 2'b00;
      aluop_c    = 2'b00;
      imm_zext_c = 1'b0;
      illegal_c  = 1'b0;
      case (state)
         S_FETCH: begin
            alusrcb_c  = 2'b01;
            irwrite_c  = ctrl.mem_ready;
            pcwrite_c  = ctrl.mem_ready;
            next_state = ctrl.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb_c = 2'b11;
            case (ctrl.opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE:     next_state = S_EXECUTE;
               OP_BEQ:       next_state = S_BRANCH;
               OP_ADDI:      next_state = S_ADDIEX;
               OP_ANDI:      next_state = S_ANDIEX;
               OP_J:         next_state = S_JUMP;
               default:      illegal_c  = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alusrca_c  = 1'b1;
            alusrcb_c  = 2'b10;
            next_state = (ctrl.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord_c     = 1'b1;
            next_state = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            regwrite_c = 1'b1;
            memtoreg_c = 1'b1;
         end
         S_MEMWR: begin
            iord_c     = 1'b1;
            memwrite_c = 1'b1;
            next_state = ctrl.mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            alusrca_c = 1'b1;
            aluop_c   = 2'b10;
            // jr resolves here: redirect PC from register A and skip writeback.
            if (ctrl.jr) begin
               pcwrite_c = 1'b1;
               pcsrc_c   = 2'b11;
            end else begin
               next_state = S_ALUWB;
            end
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            regdst_c   = 1'b1;
         end
         S_BRANCH: begin
            alusrca_c = 1'b1;
            aluop_c   = 2'b01;
            pcsrc_c   = 2'b01;
            branch_c  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca_c  = 1'b1;
            alusrcb_c  = 2'b10;
            next_state = S_IMMWB;
         end
         S_ANDIEX: begin
            alusrca_c  = 1'b1;
            alusrcb_c  = 2'b10;
            aluop_c    = 2'b11;
            imm_zext_c = 1'b1;
            next_state = S_IMMWB;
         end
         S_IMMWB: regwrite_c = 1'b1;
         S_JUMP: begin
            pcwrite_c = 1'b1;
            pcsrc_c   = 2'b10;
         end
         default: ;
      endcase
   end

   // Write strobes are masked by rst_n so FETCH's mem_ready-driven writes stay off in reset.
   assign pcwrite_g       = pcwrite_c & rst_n;
   assign ctrl.pcwrite    = pcwrite_g;
   assign ctrl.irwrite    = irwrite_c & rst_n;
   assign ctrl.memwrite   = memwrite_c & rst_n;
   assign ctrl.regwrite   = regwrite_c & rst_n;
   assign ctrl.illegal_op = illegal_c & rst_n;
   assign ctrl.pc_en      = pcwrite_g | (branch_c & ctrl.zero);
   assign ctrl.branch     = branch_c;
   assign ctrl.pcsrc      = pcsrc_c;
   assign ctrl.iord       = iord_c;
   assign ctrl.regdst     = regdst_c;
   assign ctrl.memtoreg   = memtoreg_c;
   assign ctrl.alusrca    = alusrca_c;
   assign ctrl.alusrcb    = alusrcb_c;
   assign ctrl.aluop      = aluop_c;
   assign ctrl.imm_zext   = imm_zext_c;
   assign ctrl.state_o    = state;
endmodule
